// File: rtl/register_file.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports, one synchronous write port.
// X31 (XZR) always reads zero. Define REGFILE_BYPASS_EN to forward BusW to same-cycle reads.
module register_file #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic                  RegWr,
  input  logic [DATA_WIDTH-1:0] BusW,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic                  wr_en;

  assign wr_en = RegWr && (RW != ZeroAddr);

  // The XZR entry is never written, so it simply holds its reset value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[RW] <= BusW;
    end
  end

  always_comb begin
    BusA = regs_q[RA];
    BusB = regs_q[RB];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !Reset && (RW == RA)) BusA = BusW;
    if (wr_en && !Reset && (RW == RB)) BusB = BusW;
`endif
    if (RA == ZeroAddr) BusA = '0;
    if (RB == ZeroAddr) BusB = '0;
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected BusA/BusB, a monitor pops and compares.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  RA, RB, RW;
  logic        RegWr;
  logic [63:0] BusW, BusA, BusB;

  register_file dut (
    .Clk   (Clk),
    .Reset (Reset),
    .RA    (RA),
    .RB    (RB),
    .RW    (RW),
    .RegWr (RegWr),
    .BusW  (BusW),
    .BusA  (BusA),
    .BusB  (BusB)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    string       name;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] model [32];
  int          checks = 0;
  int          errors = 0;
  bit          stim_done = 1'b0;

  function automatic logic [63:0] read_model(input logic [4:0] addr, input logic rst,
                                             input logic wr, input logic [4:0] wa,
                                             input logic [63:0] wd);
    if (addr == 5'd31 || rst) return 64'h0;
    if (Bypass && wr && wa == addr) return wd;
    return model[addr];
  endfunction

  task automatic push_exp(input string name);
    exp_t e;
    e.a    = read_model(RA, Reset, RegWr, RW, BusW);
    e.b    = read_model(RB, Reset, RegWr, RW, BusW);
    e.name = name;
    exp_q.push_back(e);
  endtask

  // One cycle: drive at negedge, record expectation, then apply the model's effect of the next edge.
  task automatic step(input string name, input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                      input logic wr, input logic [4:0] rw, input logic [63:0] w);
    @(negedge Clk);
    Reset = rst; RA = ra; RB = rb; RegWr = wr; RW = rw; BusW = w;
    if (rst) foreach (model[i]) model[i] = 64'h0;
    push_exp(name);
    if (!rst && wr && rw != 5'd31) model[rw] = w;
  endtask

  // Reset pulse confined between two edges; the monitor samples while it is high.
  task automatic pulse_reset(input string name, input logic [4:0] ra, input logic [4:0] rb);
    @(negedge Clk);
    Reset = 1'b1; RA = ra; RB = rb; RegWr = 1'b1; RW = ra; BusW = 64'hFFFF_0000_FFFF_0000;
    foreach (model[i]) model[i] = 64'h0;
    push_exp(name);
    #4;
    Reset = 1'b0; RegWr = 1'b0;
  endtask

  // Monitor: outputs are combinational, so each cycle's expectation is checked 3ns after the drive.
  initial begin
    forever begin
      @(negedge Clk);
      #3;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (BusA !== e.a || BusB !== e.b) begin
          errors++;
          $display("FAIL %s: BusA=%h BusB=%h expected BusA=%h BusB=%h", e.name, BusA, BusB, e.a, e.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  ra, rb, rw;
    logic [63:0] w;
    Reset = 1'b1; RA = '0; RB = '0; RW = '0; RegWr = 1'b0; BusW = '0;
    foreach (model[i]) model[i] = 64'h0;

    step("reset_state", 1'b1, 5'd1, 5'd30, 1'b0, 5'd0, 64'h0);
    step("reset_release", 1'b0, 5'd2, 5'd5, 1'b0, 5'd0, 64'h0);

    // Reset clear between edges
    step("wr_r5", 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001);
    step("rd_r5", 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 64'h0);
    pulse_reset("reset_pulse_r5", 5'd5, 5'd5);
    step("after_pulse_r5", 1'b0, 5'd5, 5'd5, 1'b0, 5'd0, 64'h0);

    // Write/read, both ports same index
    step("wr_r3", 1'b0, 5'd3, 5'd4, 1'b1, 5'd3, 64'h0123_4567_89AB_CDEF);
    step("rd_r3_both", 1'b0, 5'd3, 5'd3, 1'b0, 5'd0, 64'h0);

    // XZR
    step("wr_xzr", 1'b0, 5'd31, 5'd3, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    step("rd_xzr", 1'b0, 5'd31, 5'd31, 1'b0, 5'd0, 64'h0);
    for (int i = 0; i < 32; i += 2) step("sweep_after_xzr", 1'b0, 5'(i), 5'(i + 1), 1'b0, 5'd0, 64'h0);

    // Write enable low
    step("wren_low", 1'b0, 5'd7, 5'd3, 1'b0, 5'd7, 64'h55);
    step("rd_r7", 1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 64'h0);

    // Same-cycle read-after-write
    step("wr_r9", 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 64'h11);
    step("raw_r9_same", 1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 64'h22);
    step("raw_r9_after", 1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 64'h0);

    // Reset held high across an edge with a write pending
    step("rst_vs_wr", 1'b1, 5'd4, 5'd3, 1'b1, 5'd4, 64'hAA);
    step("rd_r4_after_rst", 1'b0, 5'd4, 5'd3, 1'b0, 5'd0, 64'h0);

    // Randomized traffic; narrow address range half the time to force RW/RA/RB collisions
    for (int n = 0; n < 400; n++) begin
      if (n % 2 == 0) begin
        ra = 5'($urandom_range(0, 3)) + 5'd28;
        rb = 5'($urandom_range(0, 3)) + 5'd28;
        rw = 5'($urandom_range(0, 3)) + 5'd28;
      end else begin
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
        rw = 5'($urandom_range(0, 31));
      end
      w = {$urandom, $urandom};
      if (n % 97 == 96) pulse_reset("rand_reset", ra, rb);
      else step("random", 1'b0, ra, rb, 1'($urandom_range(0, 3) != 0), rw, w);
    end

    stim_done = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
